// File: rtl/line_buf_pkg.sv
// Shared constants and pixel type for the video line buffers.
// Sized for one 1920-pixel line of 24-bit RGB.
package line_buf_pkg;

    localparam int unsigned PIX_W        = 24;
    localparam int unsigned LINE_ADDR_W  = 11;
    localparam int unsigned LINE_DEPTH   = 2048;
    localparam int unsigned ACTIVE_WIDTH = 1920;

    typedef logic [PIX_W-1:0] pixel_t;

endpackage

// File: rtl/rd_pipe_reg.sv
// Resettable register stage used as the optional second read stage.
module rd_pipe_reg #(
    parameter int unsigned DATA_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/line_buffer_sdp_ram.sv
// Simple dual-port line buffer RAM: port A write-only, port B read-only, one clock.
// Reads are read-first on collision; out-of-range accesses are dropped or read as zero.
module line_buffer_sdp_ram
    import line_buf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = PIX_W,
    parameter int unsigned ADDR_WIDTH   = LINE_ADDR_W,
    parameter int unsigned DEPTH        = LINE_DEPTH,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  wea,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [DATA_WIDTH-1:0] dina,
    input  logic [ADDR_WIDTH-1:0] addrb,
    output logic [DATA_WIDTH-1:0] doutb
);

    // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0] DepthW = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};
    logic [DATA_WIDTH-1:0] rd_q;
    logic                  wr_in_range;
    logic                  rd_in_range;

    assign wr_in_range = ({1'b0, addra} < DepthW);
    assign rd_in_range = ({1'b0, addrb} < DepthW);

    // Port A ignores reset so the array stays a plain block RAM.
    always_ff @(posedge clk) begin
        if (wea && wr_in_range) begin
            mem[addra] <= dina;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            rd_q <= '0;
        end else if (rd_in_range) begin
            rd_q <= mem[addrb];
        end else begin
            rd_q <= '0;
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        rd_pipe_reg #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_stage2 (
            .clk  (clk),
            .n_rst(n_rst),
            .d    (rd_q),
            .q    (doutb)
        );
    end else begin : g_lat1
        assign doutb = rd_q;
    end

endmodule

// File: tb/tb_line_buffer_sdp_ram.sv
// Scoreboard bench: two builds (2048/lat1 and 1920/lat2) share stimulus against array models.
module tb_line_buffer_sdp_ram;
    import line_buf_pkg::*;

    localparam int DEPTH_B = 1920;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       wea;
    logic [10:0] addra;
    logic [10:0] addrb;
    pixel_t     dina;
    pixel_t     doutb_a;
    pixel_t     doutb_b;

    always #5 clk = ~clk;

    line_buffer_sdp_ram u_dut_a (
        .clk  (clk),
        .n_rst(n_rst),
        .wea  (wea),
        .addra(addra),
        .dina (dina),
        .addrb(addrb),
        .doutb(doutb_a)
    );

    line_buffer_sdp_ram #(
        .DEPTH       (DEPTH_B),
        .READ_LATENCY(2)
    ) u_dut_b (
        .clk  (clk),
        .n_rst(n_rst),
        .wea  (wea),
        .addra(addra),
        .dina (dina),
        .addrb(addrb),
        .doutb(doutb_b)
    );

    pixel_t model_a [LINE_DEPTH];
    pixel_t model_b [DEPTH_B];
    pixel_t stage_b;
    pixel_t exp_a_q [$];
    pixel_t exp_b_q [$];
    string  tag_a_q [$];
    string  tag_b_q [$];
    string  phase;
    int     total = 0;
    int     bad = 0;

    // Drive one cycle and push what each build must show after the coming edge.
    task automatic step(input logic nr, input logic we, input int wa, input pixel_t wd,
                        input int ra);
        pixel_t rd_a;
        pixel_t rd_b;
        @(negedge clk);
        n_rst = nr;
        wea   = we;
        addra = 11'(wa);
        dina  = wd;
        addrb = 11'(ra);
        rd_a = nr ? model_a[ra] : '0;
        rd_b = (nr && ra < DEPTH_B) ? model_b[ra] : '0;
        exp_a_q.push_back(rd_a);
        tag_a_q.push_back(phase);
        exp_b_q.push_back(nr ? stage_b : '0);
        tag_b_q.push_back(phase);
        stage_b = rd_b;
        if (we) begin
            model_a[wa] = wd;
            if (wa < DEPTH_B) model_b[wa] = wd;
        end
    endtask

    initial begin : monitor
        pixel_t e;
        string  t;
        forever begin
            @(posedge clk);
            #1;
            if (exp_a_q.size() > 0) begin
                e = exp_a_q.pop_front();
                t = tag_a_q.pop_front();
                total++;
                if (doutb_a !== e) begin
                    bad++;
                    $display("FAIL %s lat1 doutb=%h expected=%h", t, doutb_a, e);
                end
            end
            if (exp_b_q.size() > 0) begin
                e = exp_b_q.pop_front();
                t = tag_b_q.pop_front();
                total++;
                if (doutb_b !== e) begin
                    bad++;
                    $display("FAIL %s lat2 doutb=%h expected=%h", t, doutb_b, e);
                end
            end
        end
    end

    initial begin : stimulus
        for (int i = 0; i < LINE_DEPTH; i++) model_a[i] = '0;
        for (int i = 0; i < DEPTH_B; i++) model_b[i] = '0;
        stage_b = '0;
        n_rst = 1'b0;
        wea   = 1'b0;
        addra = '0;
        addrb = '0;
        dina  = '0;

        phase = "reset_state";
        repeat (3) step(1'b0, 1'b0, 0, '0, 0);

        phase = "basic";
        step(1'b1, 1'b1, 0, 24'hFF0000, 0);
        step(1'b1, 1'b1, 1, 24'h00FF00, 0);
        step(1'b1, 1'b1, 1919, 24'h0000FF, 0);
        step(1'b1, 1'b0, 0, '0, 1);
        step(1'b1, 1'b0, 0, '0, 1919);
        step(1'b1, 1'b0, 0, '0, 0);

        phase = "collision";
        step(1'b1, 1'b1, 5, 24'h111111, 0);
        step(1'b1, 1'b1, 5, 24'h222222, 5);
        step(1'b1, 1'b0, 0, '0, 5);
        step(1'b1, 1'b0, 0, '0, 5);

        phase = "wea_gate";
        step(1'b1, 1'b0, 10, 24'hABCDEF, 10);
        step(1'b1, 1'b0, 0, '0, 10);
        step(1'b1, 1'b0, 0, '0, 10);

        phase = "reset_mid";
        step(1'b1, 1'b1, 300, 24'h123456, 0);
        step(1'b1, 1'b0, 0, '0, 300);
        step(1'b1, 1'b0, 0, '0, 300);
        repeat (3) step(1'b0, 1'b0, 0, '0, 300);
        repeat (3) step(1'b1, 1'b0, 0, '0, 300);

        phase = "write_in_reset";
        step(1'b0, 1'b1, 301, 24'h654321, 301);
        step(1'b1, 1'b0, 0, '0, 301);
        step(1'b1, 1'b0, 0, '0, 301);

        phase = "sweep";
        for (int i = 0; i < ACTIVE_WIDTH; i++) step(1'b1, 1'b1, i, pixel_t'(i), 0);
        step(1'b1, 1'b1, 2047, 24'hC0FFEE, 0);
        for (int i = 0; i < ACTIVE_WIDTH; i++) step(1'b1, 1'b0, 0, '0, i);
        step(1'b1, 1'b0, 0, '0, 2047);

        phase = "out_of_range";
        step(1'b1, 1'b1, 0, 24'h5A5A5A, 0);
        step(1'b1, 1'b1, 1920, 24'hDEADBE, 0);
        step(1'b1, 1'b0, 0, '0, 1920);
        step(1'b1, 1'b0, 0, '0, 0);
        step(1'b1, 1'b0, 0, '0, 2047);

        phase = "random";
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 19) != 0), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 2047)), pixel_t'($urandom),
                 int'($urandom_range(0, 2047)));
        end
        phase = "drain";
        repeat (3) step(1'b1, 1'b0, 0, '0, 0);

        // Every pushed expectation must have been consumed within a few cycles.
        for (int i = 0; i < 5 && (exp_a_q.size() + exp_b_q.size()) > 0; i++) @(negedge clk);
        total++;
        if ((exp_a_q.size() + exp_b_q.size()) != 0) begin
            bad++;
            $display("FAIL drain pending=%0d expected=0", exp_a_q.size() + exp_b_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
